// File: rtl/window_line_buffer.sv
// window_line_buffer: sliding KERNEL x KERNEL window generator for a raster
// pixel stream. Row/column tracking ensures that windows straddling a line
// or frame edge are never flagged. Output stride uses phase counters.
module window_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int KERNEL     = 3,
    parameter int STRIDE     = 1
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    clr,
    input  logic [DATA_WIDTH-1:0]                   data_in,
    input  logic                                    data_valid_in,
    output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]     win_out,
    output logic                                    valid_out,
    output logic [7:0]                              win_row,
    output logic [7:0]                              win_col,
    output logic                                    frame_done
);
    localparam int CW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PW  = (STRIDE     > 1) ? $clog2(STRIDE)     : 1;
    localparam int NLB = KERNEL - 1;

    logic              accept;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [PW-1:0]     col_ph, row_ph;
    logic [7:0]        wcol, wrow;
    logic              last_col, last_row, legal, aligned;

    // Line buffers hold the previous NLB lines; lb[0] is the most recent line.
    logic [DATA_WIDTH-1:0] lb [NLB][IMG_WIDTH];
    // win[r][c]: r=0 oldest line, c=0 oldest column; packs directly onto win_out.
    logic [KERNEL-1:0][KERNEL-1:0][DATA_WIDTH-1:0] win;
    logic [KERNEL-1:0][DATA_WIDTH-1:0]             tap;

    assign accept   = data_valid_in & ~clr;
    assign last_col = (col == CW'(IMG_WIDTH - 1));
    assign last_row = (row == RW'(IMG_HEIGHT - 1));
    assign legal    = (row >= RW'(KERNEL - 1)) && (col >= CW'(KERNEL - 1));
    assign aligned  = (row_ph == '0) && (col_ph == '0);
    assign win_out  = win;

    // Column taps: newest row is the live pixel, older rows come from the buffers.
    assign tap[KERNEL-1] = data_in;
    genvar g;
    generate
        for (g = 0; g < NLB; g++) begin : g_tap
            assign tap[g] = lb[NLB-1-g][col];
        end

        for (g = 0; g < NLB; g++) begin : g_lb
            // Each buffer shifts the pixel it held at this column into the next older buffer.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    for (int i = 0; i < IMG_WIDTH; i++) lb[g][i] <= '0;
                end else if (accept) begin
                    if (g == 0) lb[g][col] <= data_in;
                    else        lb[g][col] <= lb[(g == 0) ? 0 : g-1][col];
                end
            end
        end
    endgenerate

    // Window shift registers: every row shifts left and takes its column tap.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            win <= '0;
        end else if (accept) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL-1; c++) win[r][c] <= win[r][c+1];
                win[r][KERNEL-1] <= tap[r];
            end
        end
    end

    // Position, stride-phase and output-map counters plus registered flags.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            col <= '0; row <= '0; col_ph <= '0; row_ph <= '0;
            wcol <= '0; wrow <= '0;
            valid_out <= 1'b0; frame_done <= 1'b0;
            win_row <= '0; win_col <= '0;
        end else if (clr) begin
            col <= '0; row <= '0; col_ph <= '0; row_ph <= '0;
            wcol <= '0; wrow <= '0;
            valid_out <= 1'b0; frame_done <= 1'b0;
            win_row <= '0; win_col <= '0;
        end else if (data_valid_in) begin
            valid_out  <= legal && aligned;
            frame_done <= last_col && last_row;
            win_row    <= wrow;
            win_col    <= wcol;
            if (last_col) begin
                col    <= '0;
                col_ph <= '0;
                wcol   <= '0;
                row    <= last_row ? '0 : row + RW'(1);
                if (last_row || row < RW'(KERNEL - 1)) begin
                    row_ph <= '0;
                end else begin
                    row_ph <= (row_ph == PW'(STRIDE - 1)) ? '0 : row_ph + PW'(1);
                end
                if (last_row) wrow <= '0;
                else if (row >= RW'(KERNEL - 1) && row_ph == PW'(STRIDE - 1)) wrow <= wrow + 8'd1;
            end else begin
                col <= col + CW'(1);
                if (col < CW'(KERNEL - 1)) begin
                    col_ph <= '0;
                end else begin
                    col_ph <= (col_ph == PW'(STRIDE - 1)) ? '0 : col_ph + PW'(1);
                    if (col_ph == PW'(STRIDE - 1)) wcol <= wcol + 8'd1;
                end
            end
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end
    end
endmodule

// File: doc/window_line_buffer.md
# window_line_buffer

Parametrised sliding-window generator for the convolution datapath. It accepts a raster-order pixel stream, one pixel per enabled cycle. It presents a full KERNEL×KERNEL neighbourhood on a flat output bus. Unlike the fixed 3×3 buffer, it tracks row and column position, so windows that straddle a line or frame edge are never flagged valid. It also supports a programmable output stride and frame-level control.

## Interface
- DATA_WIDTH, 16, pixel width in bits
- IMG_WIDTH, 28, pixels per line (must be ≥ KERNEL)
- IMG_HEIGHT, 28, lines per frame (must be ≥ KERNEL)
- KERNEL, 3, window side length (supported 2..7)
- STRIDE, 1, window step in both directions (≥1)

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset; the only clock is CLK
- clr  in  1  synchronous frame restart, active high
- data_in  in  DATA_WIDTH  input pixel
- data_valid_in  in  1  pixel-accept strobe
- win_out  out  KERNEL*KERNEL*DATA_WIDTH  window; element e=r*KERNEL+c occupies bits [e*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest line; c=0 is the oldest column
- valid_out  out  1  win_out holds a legal, stride-aligned window
- win_row  out  8  output-map row index of current window
- win_col  out  8  output-map column index of current window
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Storage consists of KERNEL-1 line buffers of depth IMG_WIDTH, chained, plus a KERNEL-deep shift register per window row. All storage advances only on accepted pixels.
- Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) give the coordinates of the accepted pixel.
- On accept, col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and frame_done is asserted the next cycle.
- A window is legal when the accepted pixel has row ≥ KERNEL-1 and col ≥ KERNEL-1.
- A legal window is also stride-aligned when (row-(KERNEL-1)) mod STRIDE = 0 and (col-(KERNEL-1)) mod STRIDE = 0.
- Use phase counters for stride alignment; no divider is allowed.
- win_row = (row-(KERNEL-1))/STRIDE and win_col = (col-(KERNEL-1))/STRIDE for the flagged window. Maintain both as incrementing counters.
- The window at the bottom-right element (r=c=KERNEL-1) is the pixel just accepted.
- The window is spatially contiguous: element (r,c) equals pixel (row-(KERNEL-1)+r, col-(KERNEL-1)+c).
- When data_valid_in is low, all storage and counters hold. valid_out and frame_done are low that cycle.
- clr, on a clock edge, resets row, col, stride phases, win_row and win_col to 0. It also deasserts valid_out and frame_done.
- clr does not erase pixel storage; stale data is masked by counter gating.
- clr together with data_valid_in: clr wins and the pixel is discarded.
- Frames may be streamed back-to-back with no gap. A new frame's first line does not produce valid windows until row reaches KERNEL-1 again.

## Timing
- Reset (RST low, asynchronous): all counters, storage, win_out, win_row, win_col, valid_out and frame_done go to 0 immediately. Deassertion takes effect from the first rising edge.
- Latency is 1 cycle. The pixel accepted on edge t updates win_out, valid_out, win_row and win_col, all registered, visible after edge t.
- valid_out is high for exactly one cycle per flagged window. It is never high on a cycle without an accept on the preceding edge.
- win_out may change on any accept cycle. It is meaningful only while valid_out is high.
- Windows per frame: ((IMG_HEIGHT-KERNEL)/STRIDE+1) × ((IMG_WIDTH-KERNEL)/STRIDE+1), using integer division.
- frame_done coincides with valid_out of the last window when that window is aligned to the final pixel.
- Reset mid-frame discards the frame. The next accepted pixel is (0,0).

## Test plan
- KERNEL=3, STRIDE=1, IMG 6×6, data = row*6+col, continuous valid -> first valid_out after pixel 14 is accepted, with win_out = {0,1,2,6,7,8,12,13,14} (e=0..8). Exactly 16 valid pulses occur; the last window is {21,22,23,27,28,29,33,34,35} with win_row=win_col=3. frame_done pulses once.
- Same config with data_valid_in toggling 1/0 randomly -> identical window sequence and count. valid_out is never high on a hold cycle.
- STRIDE=2, 6×6 -> exactly 4 valid windows, at pixels 14, 16, 26 and 28. win_row/win_col are (0,0), (0,1), (1,0), (1,1).
- KERNEL=5, IMG 7×7 -> 9 windows. The first is at pixel 32 with element 0 = 0 and element 24 = 32.
- Two back-to-back frames -> no valid_out during the first KERNEL-1 lines of frame 2. Window values in frame 2 match frame 1 for identical data.
- RST low mid-frame, and separately clr asserted with data_valid_in high -> outputs go to 0. The next accepted pixel is treated as (0,0), and the pixel coincident with clr is not stored.
